item_pool_scheduler: RTL and testbench

//  Manages a pool of simultaneously active power-up items on the map. Freed blocks become

---
 rtl/item_pool_scheduler_pkg.sv | 24 ++
 rtl/item_pool_scheduler_if.sv | 51 +++++
 rtl/item_pool_scheduler_item_slot.sv | 74 +++++++
 rtl/item_pool_scheduler.sv | 154 +++++++++++++++
 tb/tb_item_pool_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/item_pool_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module  : item_pool_scheduler_pkg
// Brief   : Shared types and map defaults for the power-up item pool.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package item_pool_scheduler_pkg;

    localparam int MAP_NUM_ROW_DEF    = 11;
    localparam int MAP_NUM_COL_DEF    = 19;
    localparam int MAP_MEM_WIDTH_DEF  = 2;
    localparam int ITEM_TICKS_PER_SEC = 60;

    typedef enum logic [1:0] {
        ITEM_SPEED = 2'd0,
        ITEM_RANGE = 2'd1,
        ITEM_BOMB  = 2'd2,
        ITEM_LIFE  = 2'd3
    } item_type_t;

endpackage

`default_nettype wire

// File: rtl/item_pool_scheduler_if.sv
//------------------------------------------------------------------------------
// Module  : item_pool_scheduler_if
// Brief   : Map-write, player, query and pickup signals of the item pool.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface item_pool_scheduler_if #(
    parameter int AW = 8,
    parameter int DW = 2,
    parameter int CW = 3
);
    logic          tick;
    logic          game_over;
    logic          we_in;
    logic [AW-1:0] write_addr_in;
    logic [DW-1:0] write_data_in;
    logic          spawn_roll;
    logic [1:0]    type_rand;
    logic [AW-1:0] p1_blk1_addr;
    logic [AW-1:0] p1_blk2_addr;
    logic [AW-1:0] p2_blk1_addr;
    logic [AW-1:0] p2_blk2_addr;
    logic [AW-1:0] query_addr;
    logic          query_hit;
    logic [1:0]    query_type;
    logic          p1_pickup;
    logic [1:0]    p1_pickup_type;
    logic          p2_pickup;
    logic [1:0]    p2_pickup_type;
    logic [CW-1:0] active_cnt;

    modport master (
        output tick, game_over, we_in, write_addr_in, write_data_in, spawn_roll,
               type_rand, p1_blk1_addr, p1_blk2_addr, p2_blk1_addr, p2_blk2_addr,
               query_addr,
        input  query_hit, query_type, p1_pickup, p1_pickup_type, p2_pickup,
               p2_pickup_type, active_cnt
    );

    modport slave (
        input  tick, game_over, we_in, write_addr_in, write_data_in, spawn_roll,
               type_rand, p1_blk1_addr, p1_blk2_addr, p2_blk1_addr, p2_blk2_addr,
               query_addr,
        output query_hit, query_type, p1_pickup, p1_pickup_type, p2_pickup,
               p2_pickup_type, active_cnt
    );

endinterface

`default_nettype wire

// File: rtl/item_pool_scheduler_item_slot.sv
//------------------------------------------------------------------------------
// Module  : item_pool_scheduler_item_slot
// Brief   : One item slot: valid/addr/type/life registers plus address compares.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module item_pool_scheduler_item_slot
    import item_pool_scheduler_pkg::*;
#(
    parameter int AW        = 8,
    parameter int ITEM_TIME = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_tick,
    input  wire logic          i_load,
    input  wire logic          i_take,
    input  wire logic [AW-1:0] i_load_addr,
    input  wire item_type_t    i_load_type,
    input  wire logic [AW-1:0] i_query_addr,
    input  wire logic [AW-1:0] i_write_addr,
    input  wire logic [AW-1:0] i_p1_blk1,
    input  wire logic [AW-1:0] i_p1_blk2,
    input  wire logic [AW-1:0] i_p2_blk1,
    input  wire logic [AW-1:0] i_p2_blk2,
    output logic               o_valid,
    output item_type_t         o_type,
    output logic               o_hit_query,
    output logic               o_hit_write,
    output logic               o_touch_p1,
    output logic               o_touch_p2
);

    localparam int C_LIFE = ITEM_TIME * ITEM_TICKS_PER_SEC;
    localparam int C_LW   = $clog2(C_LIFE + 1);

    logic            r_valid;
    logic [AW-1:0]   r_addr;
    item_type_t      r_type;
    logic [C_LW-1:0] r_life;

    // A take always wins over the tick that would have expired the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_type  <= ITEM_SPEED;
            r_life  <= '0;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_load_addr;
            r_type  <= i_load_type;
            r_life  <= C_LW'(C_LIFE);
        end else if (r_valid && i_tick) begin
            r_life <= r_life - 1'b1;
            if (r_life == C_LW'(1)) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_type      = r_type;
    assign o_hit_query = r_valid && (r_addr == i_query_addr);
    assign o_hit_write = r_valid && (r_addr == i_write_addr);
    assign o_touch_p1  = r_valid && ((r_addr == i_p1_blk1) || (r_addr == i_p1_blk2));
    assign o_touch_p2  = r_valid && ((r_addr == i_p2_blk1) || (r_addr == i_p2_blk2));

endmodule

`default_nettype wire

// File: rtl/item_pool_scheduler.sv
//------------------------------------------------------------------------------
// Module  : item_pool_scheduler
// Brief   : Allocates, times out and arbitrates pickups of map power-up items.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module item_pool_scheduler
    import item_pool_scheduler_pkg::*;
#(
    parameter int NUM_ROW       = MAP_NUM_ROW_DEF,
    parameter int NUM_COL       = MAP_NUM_COL_DEF,
    parameter int MAP_MEM_WIDTH = MAP_MEM_WIDTH_DEF,
    parameter int NUM_SLOTS     = 4,
    parameter int ITEM_TIME     = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    item_pool_scheduler_if.slave bus
);

    localparam int C_DEPTH = NUM_ROW * NUM_COL;
    localparam int C_AW    = $clog2(C_DEPTH);
    localparam int C_SW    = $clog2(NUM_SLOTS);

    logic                 w_clr;
    logic [NUM_SLOTS-1:0] w_valid, w_hit_q, w_hit_w, w_touch1, w_touch2;
    logic [NUM_SLOTS-1:0] w_take, w_load;
    item_type_t           w_slot_type [NUM_SLOTS];

    logic                 w_f1, w_f2, w_a1, w_a2, w_g1, w_g2, w_tie, w_ff, w_spawn;
    logic [C_SW-1:0]      w_i1, w_i2, w_ai1, w_ai2, w_gi1, w_gi2, w_fi;
    logic [C_SW:0]        w_cnt;

    logic                 r_tie_p2;
    logic                 r_p1_pickup, r_p2_pickup;
    item_type_t           r_p1_type, r_p2_type;

    assign w_clr = rst || bus.game_over;

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            item_pool_scheduler_item_slot #(
                .AW        (C_AW),
                .ITEM_TIME (ITEM_TIME)
            ) u_item_slot (
                .clk          (clk),
                .rst          (w_clr),
                .i_tick       (bus.tick),
                .i_load       (w_load[g]),
                .i_take       (w_take[g]),
                .i_load_addr  (bus.write_addr_in),
                .i_load_type  (item_type_t'(bus.type_rand)),
                .i_query_addr (bus.query_addr),
                .i_write_addr (bus.write_addr_in),
                .i_p1_blk1    (bus.p1_blk1_addr),
                .i_p1_blk2    (bus.p1_blk2_addr),
                .i_p2_blk1    (bus.p2_blk1_addr),
                .i_p2_blk2    (bus.p2_blk2_addr),
                .o_valid      (w_valid[g]),
                .o_type       (w_slot_type[g]),
                .o_hit_query  (w_hit_q[g]),
                .o_hit_write  (w_hit_w[g]),
                .o_touch_p1   (w_touch1[g]),
                .o_touch_p2   (w_touch2[g])
            );
        end
    endgenerate

    // Lowest and next-lowest touched slot per player, then tie resolution.
    always_comb begin : p_pickup_arb
        logic [NUM_SLOTS-1:0] v_m1, v_m2;
        w_f1 = 1'b0; w_i1 = '0; w_f2 = 1'b0; w_i2 = '0;
        w_a1 = 1'b0; w_ai1 = '0; w_a2 = 1'b0; w_ai2 = '0;
        w_g1 = 1'b0; w_gi1 = '0; w_g2 = 1'b0; w_gi2 = '0;
        w_take = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_touch1[i]) begin w_f1 = 1'b1; w_i1 = C_SW'(i); end
            if (w_touch2[i]) begin w_f2 = 1'b1; w_i2 = C_SW'(i); end
        end
        v_m1 = w_touch1;
        v_m2 = w_touch2;
        v_m1[w_i1] = 1'b0;
        v_m2[w_i2] = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (v_m1[i]) begin w_a1 = 1'b1; w_ai1 = C_SW'(i); end
            if (v_m2[i]) begin w_a2 = 1'b1; w_ai2 = C_SW'(i); end
        end
        w_tie = w_f1 && w_f2 && (w_i1 == w_i2);
        if (!w_tie) begin
            w_g1 = w_f1; w_gi1 = w_i1;
            w_g2 = w_f2; w_gi2 = w_i2;
        end else if (!r_tie_p2) begin
            w_g1 = 1'b1; w_gi1 = w_i1;
            w_g2 = w_a2; w_gi2 = w_ai2;
        end else begin
            w_g2 = 1'b1; w_gi2 = w_i2;
            w_g1 = w_a1; w_gi1 = w_ai1;
        end
        if (w_g1) w_take[w_gi1] = 1'b1;
        if (w_g2) w_take[w_gi2] = 1'b1;
    end

    // Allocation looks only at slots free before this edge.
    always_comb begin : p_alloc
        w_ff   = 1'b0;
        w_fi   = '0;
        w_load = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin w_ff = 1'b1; w_fi = C_SW'(i); end
        end
        w_spawn = bus.we_in && (bus.write_data_in == '0) && bus.spawn_roll
                  && !(|w_hit_w) && w_ff;
        if (w_spawn) w_load[w_fi] = 1'b1;
    end

    always_comb begin : p_query
        bus.query_hit  = 1'b0;
        bus.query_type = 2'd0;
        w_cnt          = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_hit_q[i]) begin
                bus.query_hit  = 1'b1;
                bus.query_type = w_slot_type[i];
            end
            w_cnt = w_cnt + (C_SW + 1)'(w_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_p1_pickup <= 1'b0;
            r_p2_pickup <= 1'b0;
            r_p1_type   <= ITEM_SPEED;
            r_p2_type   <= ITEM_SPEED;
            r_tie_p2    <= 1'b0;
        end else begin
            r_p1_pickup <= w_g1;
            r_p2_pickup <= w_g2;
            if (w_g1) r_p1_type <= w_slot_type[w_gi1];
            if (w_g2) r_p2_type <= w_slot_type[w_gi2];
            if (w_tie) r_tie_p2 <= ~r_tie_p2;
        end
    end

    assign bus.p1_pickup      = r_p1_pickup;
    assign bus.p2_pickup      = r_p2_pickup;
    assign bus.p1_pickup_type = r_p1_type;
    assign bus.p2_pickup_type = r_p2_type;
    assign bus.active_cnt     = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_item_pool_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_item_pool_scheduler
// Brief   : Directed scenarios plus random traffic against a behavioural pool model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_item_pool_scheduler;
    import item_pool_scheduler_pkg::*;

    localparam int AW   = $clog2(MAP_NUM_ROW_DEF * MAP_NUM_COL_DEF);
    localparam int NS   = 4;
    localparam int IT   = 2;
    localparam int LIFE = IT * 60;

    logic clk = 1'b0;
    logic rst;

    item_pool_scheduler_if #(.AW(AW), .DW(MAP_MEM_WIDTH_DEF), .CW(3)) bus ();

    item_pool_scheduler #(
        .NUM_SLOTS (NS),
        .ITEM_TIME (IT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference pool: one entry per slot, indices are allocation priority.
    bit m_valid [NS];
    int m_addr  [NS];
    int m_type  [NS];
    int m_life  [NS];
    bit m_tie_p2;
    bit m_p1pu, m_p2pu;
    int m_p1t, m_p2t;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NS-1:0] m, input int skip);
        for (int i = 0; i < NS; i++) if (m[i] && i != skip) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0; m_addr[i] = 0; m_type[i] = 0; m_life[i] = 0;
        end
        m_tie_p2 = 0; m_p1pu = 0; m_p2pu = 0; m_p1t = 0; m_p2t = 0;
    endtask

    task automatic model_update();
        logic [NS-1:0] t1, t2, fr;
        int c1, c2, g1, g2, f;
        bit dup;
        if (rst || bus.game_over) begin
            model_clear();
            return;
        end
        dup = 0;
        for (int i = 0; i < NS; i++) begin
            t1[i] = m_valid[i] && (m_addr[i] == int'(bus.p1_blk1_addr) || m_addr[i] == int'(bus.p1_blk2_addr));
            t2[i] = m_valid[i] && (m_addr[i] == int'(bus.p2_blk1_addr) || m_addr[i] == int'(bus.p2_blk2_addr));
            fr[i] = !m_valid[i];
            if (m_valid[i] && m_addr[i] == int'(bus.write_addr_in)) dup = 1;
        end
        c1 = lowest(t1, -1);
        c2 = lowest(t2, -1);
        g1 = c1; g2 = c2;
        if (c1 >= 0 && c1 == c2) begin
            if (!m_tie_p2) g2 = lowest(t2, c1);
            else           g1 = lowest(t1, c2);
            m_tie_p2 = !m_tie_p2;
        end
        m_p1pu = (g1 >= 0);
        m_p2pu = (g2 >= 0);
        if (g1 >= 0) m_p1t = m_type[g1];
        if (g2 >= 0) m_p2t = m_type[g2];
        f = lowest(fr, -1);
        for (int i = 0; i < NS; i++) begin
            if (i == g1 || i == g2) m_valid[i] = 0;
            else if (m_valid[i] && bus.tick) begin
                if (m_life[i] == 1) m_valid[i] = 0;
                m_life[i]--;
            end
        end
        if (bus.we_in && bus.write_data_in == 0 && bus.spawn_roll && !dup && f >= 0) begin
            m_valid[f] = 1;
            m_addr[f]  = int'(bus.write_addr_in);
            m_type[f]  = int'(bus.type_rand);
            m_life[f]  = LIFE;
        end
    endtask

    // Compare every output at the falling edge, then advance the model over the rising edge.
    task automatic step();
        int eh, et, ec;
        @(negedge clk);
        eh = 0; et = 0; ec = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (m_valid[i]) ec++;
            if (m_valid[i] && m_addr[i] == int'(bus.query_addr)) begin eh = 1; et = m_type[i]; end
        end
        check_value("query_hit",      bus.query_hit,      eh);
        check_value("query_type",     bus.query_type,     et);
        check_value("active_cnt",     bus.active_cnt,     ec);
        check_value("p1_pickup",      bus.p1_pickup,      m_p1pu);
        check_value("p1_pickup_type", bus.p1_pickup_type, m_p1t);
        check_value("p2_pickup",      bus.p2_pickup,      m_p2pu);
        check_value("p2_pickup_type", bus.p2_pickup_type, m_p2t);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.tick = 0; bus.game_over = 0; bus.we_in = 0;
        bus.write_addr_in = '0; bus.write_data_in = '0; bus.spawn_roll = 0; bus.type_rand = '0;
        bus.p1_blk1_addr = AW'(200); bus.p1_blk2_addr = AW'(201);
        bus.p2_blk1_addr = AW'(202); bus.p2_blk2_addr = AW'(203);
    endtask

    task automatic spawn(input int addr, input int typ);
        bus.we_in = 1; bus.write_data_in = '0; bus.spawn_roll = 1;
        bus.write_addr_in = AW'(addr); bus.type_rand = 2'(typ);
        step();
        bus.we_in = 0;
    endtask

    task automatic probe(input int addr);
        bus.query_addr = AW'(addr);
        #1;
    endtask

    initial begin
        idle();
        bus.query_addr = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        step();
        check_value("rst_cnt", bus.active_cnt, 0);
        rst = 0;

        // spawn and visibility
        spawn(37, 2);
        probe(37);
        check_value("spawn_hit", bus.query_hit, 1);
        check_value("spawn_type", bus.query_type, 2);
        check_value("spawn_cnt", bus.active_cnt, 1);

        // filtered events
        bus.we_in = 1; bus.spawn_roll = 1; bus.write_data_in = 2'd1; bus.write_addr_in = AW'(40);
        step();
        bus.write_data_in = '0; bus.spawn_roll = 0;
        step();
        bus.spawn_roll = 1; bus.write_addr_in = AW'(37);
        step();
        idle();
        check_value("filter_cnt", bus.active_cnt, 1);

        // expiry after exactly LIFE ticks
        bus.tick = 1;
        repeat (LIFE - 1) step();
        check_value("expiry_alive", bus.query_hit, 1);
        step();
        bus.tick = 0;
        check_value("expiry_gone", bus.query_hit, 0);
        check_value("expiry_nopu", bus.p1_pickup, 0);

        // full pool, then refill into the freed slot
        for (int a = 10; a < 15; a++) spawn(a, a % 4);
        probe(14);
        check_value("full_cnt", bus.active_cnt, 4);
        check_value("full_drop", bus.query_hit, 0);
        bus.p1_blk1_addr = AW'(10);
        step();
        check_value("full_pu", bus.p1_pickup, 1);
        check_value("full_pu_type", bus.p1_pickup_type, 2);
        idle();
        spawn(14, 1);
        check_value("refill_hit", bus.query_hit, 1);
        check_value("refill_cnt", bus.active_cnt, 4);

        // tie alternation and one pickup per player per cycle
        bus.game_over = 1; step(); bus.game_over = 0;
        spawn(37, 1);
        bus.p1_blk1_addr = AW'(37); bus.p2_blk1_addr = AW'(37);
        step();
        check_value("tie1_p1", bus.p1_pickup, 1);
        check_value("tie1_p2", bus.p2_pickup, 0);
        spawn(37, 3);
        step();
        check_value("tie2_p1", bus.p1_pickup, 0);
        check_value("tie2_p2", bus.p2_pickup, 1);
        check_value("tie2_type", bus.p2_pickup_type, 3);
        idle();
        spawn(20, 1);
        spawn(21, 2);
        bus.p1_blk1_addr = AW'(20); bus.p1_blk2_addr = AW'(21);
        step();
        check_value("two_first", bus.p1_pickup_type, 1);
        step();
        check_value("two_second", bus.p1_pickup_type, 2);
        check_value("two_pulse", bus.p1_pickup, 1);
        idle();

        // pickup on the expiring tick, then game_over mid-life
        spawn(50, 0);
        bus.tick = 1;
        repeat (LIFE - 1) step();
        bus.p1_blk1_addr = AW'(50);
        step();
        check_value("race_pu", bus.p1_pickup, 1);
        idle();
        spawn(60, 3);
        bus.tick = 1;
        repeat (5) step();
        bus.p1_blk1_addr = AW'(60); bus.game_over = 1;
        step();
        check_value("go_pu", bus.p1_pickup, 0);
        check_value("go_cnt", bus.active_cnt, 0);
        idle();

        // random traffic on a small address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            bus.we_in         = ($urandom_range(0, 1) == 1);
            bus.write_addr_in = AW'($urandom_range(0, 7));
            bus.write_data_in = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            bus.spawn_roll    = ($urandom_range(0, 3) != 0);
            bus.type_rand     = 2'($urandom);
            bus.tick          = ($urandom_range(0, 1) == 1);
            bus.game_over     = ($urandom_range(0, 499) == 0);
            bus.p1_blk1_addr  = AW'($urandom_range(0, 15));
            bus.p1_blk2_addr  = AW'($urandom_range(0, 15));
            bus.p2_blk1_addr  = AW'($urandom_range(0, 15));
            bus.p2_blk2_addr  = AW'($urandom_range(0, 15));
            bus.query_addr    = AW'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
